// File: rtl/period_gen_pkg.sv
// period_gen_pkg: shared types and constants for the period generator.
//   state_e    : generator FSM states
//   MIN_PERIOD : smallest legal period code; a requested 0 is raised to this
package period_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

  localparam int unsigned MIN_PERIOD = 1;

endpackage

// File: rtl/period_gen_if.sv
// period_gen_if: valid/ready channel carrying period codes into period_gen.
//   period_in    : requested falling-edge-to-falling-edge interval code P
//   period_valid : period_in is valid this cycle
//   period_ready : consumer accepts period_in this cycle
interface period_gen_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] period_in;
  logic             period_valid;
  logic             period_ready;

  modport master (
    output period_in,
    output period_valid,
    input  period_ready
  );

  modport slave (
    input  period_in,
    input  period_valid,
    output period_ready
  );

endinterface

// File: rtl/period_gen_phase_cnt.sv
// period_gen_phase_cnt: loadable down-counter timing one phase of a symbol.
//   clk, reset : clock, async active-low reset (count cleared to 0)
//   load       : load load_val (has priority over dec)
//   dec        : decrement by one, saturating at zero
//   load_val   : value to load
//   zero_c     : count is zero (combinational decode of the count flop)
module period_gen_phase_cnt #(
  parameter int unsigned CW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          zero_c
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/period_gen.sv
// period_gen: emits one symbol of P+1 cycles (falling edge to falling edge)
// per accepted period code P; low for (P+1)>>1 cycles, then high for the rest.
// A one-entry hold register lets the next code queue up so symbols can run
// back to back without a gap.
//   clk, reset  : clock, async active-low reset
//   pif         : period code channel (slave side)
//   signal_out  : generated waveform, idle high
//   busy        : a symbol is in progress
//   underrun    : pulse, a symbol ended with no next code available
//   clamp_err   : pulse, an accepted code of 0 was raised to 1
module period_gen
  import period_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  period_gen_if.slave  pif,
  output logic         signal_out,
  output logic         busy,
  output logic         underrun,
  output logic         clamp_err
);

  localparam int unsigned CW = WIDTH + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             signal_out_q, signal_out_d;
  logic             busy_q, busy_d;
  logic             underrun_q, underrun_d;
  logic             clamp_err_q, clamp_err_d;

  logic             cnt_load, cnt_dec, cnt_zero_c;
  logic [CW-1:0]    cnt_val;
  logic             ready_c, accept_c;
  logic [WIDTH-1:0] p_in_c;

  // Low-phase length minus one; symbol length computed in CW bits so P=max cannot wrap
  function automatic logic [CW-1:0] low_m1(input logic [WIDTH-1:0] p);
    logic [CW-1:0] s;
    s = {1'b0, p} + CW'(1);
    return (s >> 1) - CW'(1);
  endfunction

  // High-phase length minus one
  function automatic logic [CW-1:0] high_m1(input logic [WIDTH-1:0] p);
    logic [CW-1:0] s;
    s = {1'b0, p} + CW'(1);
    return s - (s >> 1) - CW'(1);
  endfunction

  // Ready depends only on registered state (and reset), never on valid
  assign ready_c  = reset && ((state_q == IDLE) || !hold_full_q);
  assign accept_c = pif.period_valid && ready_c;
  assign p_in_c   = (pif.period_in == '0) ? WIDTH'(MIN_PERIOD) : pif.period_in;

  assign pif.period_ready = ready_c;

  period_gen_phase_cnt #(.CW(CW)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero_c   (cnt_zero_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counter control, active/hold register updates
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    cnt_val     = '0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          active_d = p_in_c;
          cnt_load = 1'b1;
          cnt_val  = low_m1(p_in_c);
          state_d  = LOW;
        end
      end
      LOW: begin
        if (cnt_zero_c) begin
          cnt_load = 1'b1;
          cnt_val  = high_m1(active_q);
          state_d  = HIGH;
        end else begin
          cnt_dec = 1'b1;
        end
        if (accept_c) begin
          hold_d      = p_in_c;
          hold_full_d = 1'b1;
        end
      end
      HIGH: begin
        if (!cnt_zero_c) begin
          cnt_dec = 1'b1;
          if (accept_c) begin
            hold_d      = p_in_c;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          active_d    = hold_q;
          hold_full_d = 1'b0;
          cnt_load    = 1'b1;
          cnt_val     = low_m1(hold_q);
          state_d     = LOW;
        end else if (accept_c) begin
          // Code arriving on the terminal cycle bypasses the hold register
          active_d = p_in_c;
          cnt_load = 1'b1;
          cnt_val  = low_m1(p_in_c);
          state_d  = LOW;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode, registered below so every output comes from a flop
  always_comb begin
    signal_out_d = (state_d != LOW);
    busy_d       = (state_d != IDLE);
    underrun_d   = (state_q == HIGH) && cnt_zero_c && (state_d == IDLE);
    clamp_err_d  = accept_c && (pif.period_in == '0);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q     <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      signal_out_q <= 1'b1;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
      clamp_err_q  <= 1'b0;
    end else begin
      active_q     <= active_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      signal_out_q <= signal_out_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
      clamp_err_q  <= clamp_err_d;
    end
  end

  assign signal_out = signal_out_q;
  assign busy       = busy_q;
  assign underrun   = underrun_q;
  assign clamp_err  = clamp_err_q;

endmodule

// File: tb/tb_period_gen.sv
// tb_period_gen: directed bench for period_gen. Expected symbol shapes are
// queued as codes are accepted; a monitor measures low/high phase lengths of
// signal_out and checks each finished symbol against the queue head.
module tb_period_gen;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic signal_out, busy, underrun, clamp_err;

  always #5 clk = ~clk;

  period_gen_if #(.WIDTH(8)) pif ();

  period_gen #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .pif        (pif),
    .signal_out (signal_out),
    .busy       (busy),
    .underrun   (underrun),
    .clamp_err  (clamp_err)
  );

  typedef struct {
    int p;
    int lo;
    int hi;
  } sym_t;

  sym_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Symbol shape from the code: S=P+1 (P=0 treated as 1), low S>>1, high the rest
  function automatic sym_t model(input int p);
    sym_t r;
    int   s;
    r.p  = p;
    s    = ((p == 0) ? 1 : p) + 1;
    r.lo = s / 2;
    r.hi = s - r.lo;
    return r;
  endfunction

  // ---------------- monitor ----------------
  int lo_n  = 0;
  int hi_n  = 0;
  int phase = 0;  // 0 idle, 1 in low phase, 2 in high phase

  task automatic finish_sym();
    sym_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL symbol: got unexpected symbol low %0d high %0d, expected none", lo_n, hi_n);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("low_len P=%0d", e.p), 32'(lo_n), 32'(e.lo));
      chk($sformatf("high_len P=%0d", e.p), 32'(hi_n), 32'(e.hi));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      phase = 0;
      lo_n  = 0;
      hi_n  = 0;
    end else if (signal_out === 1'b0) begin
      if (phase == 2) finish_sym();
      if (phase != 1) begin
        phase = 1;
        lo_n  = 0;
      end
      lo_n++;
    end else if (busy === 1'b1 && phase != 0) begin
      if (phase == 1) begin
        phase = 2;
        hi_n  = 0;
      end
      hi_n++;
    end else if (phase != 0) begin
      finish_sym();
      phase = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Present p from a negedge, wait for ready, return on the accepting posedge.
  // valid is left high so streams can follow without a gap.
  task automatic send(input int p, output int waits);
    @(negedge clk);
    pif.period_in    = 8'(p);
    pif.period_valid = 1'b1;
    waits = 0;
    while (pif.period_ready !== 1'b1 && waits < 600) begin
      @(negedge clk);
      waits++;
    end
    if (pif.period_ready !== 1'b1) begin
      chk($sformatf("ready_timeout P=%0d", p), 32'(pif.period_ready), 32'd1);
    end else begin
      exp_q.push_back(model(p));
      @(posedge clk);
    end
  endtask

  task automatic drop();
    @(negedge clk);
    pif.period_valid = 1'b0;
  endtask

  task automatic wait_underrun(input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (underrun === 1'b1) found = 1'b1;
    end
    #1;
    chk("underrun_seen", 32'(found), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_signal_out", 32'(signal_out), 32'd1);
    chk("symbols_done_before_underrun", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("underrun_one_cycle", 32'(underrun), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    pif.period_valid = 1'b0;
    pif.period_in    = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_signal_out", 32'(signal_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_clamp_err", 32'(clamp_err), 32'd0);
    chk("rst_ready", 32'(pif.period_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("ready_after_release", 32'(pif.period_ready), 32'd1);

    // single P=5 from idle
    send(5, w);
    #1;
    chk("p5_first_fall", 32'(signal_out), 32'd0);
    chk("p5_busy", 32'(busy), 32'd1);
    drop();
    wait_underrun(40);

    // stream 5, 9, 1 with valid held high
    send(5, w);
    send(9, w);
    chk("stream_p9_into_hold", 32'(w), 32'd0);
    send(1, w);
    chk("ready_low_while_hold_full", 32'(w > 0), 32'd1);
    drop();
    wait_underrun(60);

    // P=0 clamps to 1
    send(0, w);
    #1;
    chk("clamp_err_pulse", 32'(clamp_err), 32'd1);
    drop();
    @(posedge clk);
    #1;
    chk("clamp_err_cleared", 32'(clamp_err), 32'd0);
    wait_underrun(20);

    // largest code
    send(255, w);
    drop();
    wait_underrun(600);

    // valid arrives exactly on the HIGH terminal cycle of P=3
    send(3, w);
    drop();
    repeat (3) @(posedge clk);
    send(4, w);
    chk("terminal_ready", 32'(w), 32'd0);
    #1;
    chk("terminal_immediate_fall", 32'(signal_out), 32'd0);
    chk("terminal_no_underrun", 32'(underrun), 32'd0);
    chk("terminal_busy", 32'(busy), 32'd1);
    drop();
    wait_underrun(30);

    // reset in the middle of the low phase of P=20
    send(20, w);
    drop();
    repeat (4) @(posedge clk);
    #2;
    chk("mid_low_before_reset", 32'(signal_out), 32'd0);
    reset = 1'b0;
    #1;
    chk("async_rst_signal_out", 32'(signal_out), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ready", 32'(pif.period_ready), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_no_edge", 32'(signal_out), 32'd1);
    chk("post_rst_idle", 32'(busy), 32'd0);
    send(3, w);
    drop();
    wait_underrun(20);

    chk("no_leftover_symbols", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
